// File: rtl/mpadder3_seq_pkg.sv
// Shared definitions for the chunked three-operand adder: default sizes, FSM encoding
// and the chunk-count helper.
package mpadder3_seq_pkg;

    localparam int unsigned DefWidth = 1027;
    localparam int unsigned DefChunk = 64;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // ceil((width + 1) / chunk): the result is one bit wider than the operands
    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return (width + chunk) / chunk;
    endfunction

endpackage

// File: rtl/mpadd_chunk.sv
// Combinational CHUNK-bit three-input adder with a 2-bit carry in and out.
module mpadd_chunk #(
    parameter int unsigned CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [CHUNK-1:0] c,
    input  logic [1:0]       cin,
    output logic [CHUNK-1:0] sum,
    output logic [1:0]       cout
);

    // Worst case 3*(2^CHUNK-1)+2 fits in CHUNK+2 bits, so cout never exceeds 2
    always_comb begin
        {cout, sum} = {2'b00, a} + {2'b00, b} + {2'b00, c} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/mpadder3_seq.sv
// Multi-cycle a + b +/- c over WIDTH-bit operands, CHUNK bits per clock, with a
// start/done handshake. Result is WIDTH+1 bits, modulo 2^(WIDTH+1).
module mpadder3_seq
    import mpadder3_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CHUNK = DefChunk
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned EXT    = NCHUNK * CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NCHUNK - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [EXT-1:0] a_q, b_q, c_q, res_q, res_d;
    logic [1:0]     carry_q, carry_d;
    logic [CHUNK-1:0] sum;
    logic           accept, last;

    assign accept = (state_q == StIdle) && start;
    assign last   = (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        unique case (state_q)
            StRun:  busy = 1'b1;
            StDone: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                done = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    mpadd_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a   (a_q[CHUNK-1:0]),
        .b   (b_q[CHUNK-1:0]),
        .c   (c_q[CHUNK-1:0]),
        .cin (carry_q),
        .sum (sum),
        .cout(carry_d)
    );

    // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at the bottom
    always_comb begin
        res_d = res_q >> CHUNK;
        res_d[EXT-1 -: CHUNK] = sum;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= EXT'(in_a);
            b_q     <= EXT'(in_b);
            // Subtraction as a + b + ~c + 1; the +1 enters through the initial carry
            c_q     <= subtract ? ~EXT'(in_c) : EXT'(in_c);
            carry_q <= {1'b0, subtract};
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            c_q     <= c_q >> CHUNK;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign result = res_q[WIDTH:0];

    if (EXT > WIDTH + 1) begin : g_res_pad
        logic unused_res_hi;
        assign unused_res_hi = ^res_q[EXT-1:WIDTH+1];
    end

endmodule

// File: tb/tb_mpadder3_seq.sv
// Self-checking bench for mpadder3_seq: directed corner cases plus randomized operations
// compared against a plain modular-arithmetic reference.
module tb_mpadder3_seq;

    localparam int W = 1027;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] in_c = '0;
    logic [W:0]   result;
    logic         done;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mpadder3_seq dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .subtract(subtract),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_c    (in_c),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    // Reference: (a + b +/- c) mod 2^(W+1)
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic sub);
        logic [W:0] ea, eb, ec;
        ea = {1'b0, a};
        eb = {1'b0, b};
        ec = {1'b0, c};
        return sub ? (ea + eb - ec) : (ea + eb + ec);
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [1055:0] t;
        int unsigned m;
        m = $urandom_range(0, 7);
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        if (m == 0) t = '0;
        else if (m == 1) t = '1;
        return t[W-1:0];
    endfunction

    // One operation: lat counts edges from the start-sampling edge (inclusive) to done
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic sub, output logic [W:0] res, output int lat,
                         output int busy_cycles);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_c = c;
        subtract = sub;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (busy) busy_cycles++;
        res = result;
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result got %h want 0", result[127:0]);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b want 0", done);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        logic [W:0] r;
        int lat, bc;
        do_op(1, 1, 1, 1'b0, r, lat, bc);
        n_checks++;
        if (r !== (W+1)'(3)) begin
            n_fail++;
            $display("FAIL basic_result got %h want 3", r[127:0]);
        end
        n_checks++;
        if (lat != 18) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 18", lat);
        end
        n_checks++;
        if (bc != 18) begin
            n_fail++;
            $display("FAIL basic_busy_cycles got %0d want 18", bc);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse got %b want 0", done);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_busy got %b want 0", busy);
        end
        n_checks++;
        if (result !== (W+1)'(3)) begin
            n_fail++;
            $display("FAIL basic_hold got %h want 3", result[127:0]);
        end
    endtask

    task automatic test_subtract();
        logic [W:0] r, exp;
        int lat, bc;
        exp = '1;
        exp[0] = 1'b0;
        do_op(5, 0, 7, 1'b1, r, lat, bc);
        n_checks++;
        if (r !== exp) begin
            n_fail++;
            $display("FAIL sub_negative got %h want %h", r[127:0], exp[127:0]);
        end
        n_checks++;
        if (lat != 18) begin
            n_fail++;
            $display("FAIL sub_latency got %0d want 18", lat);
        end
    endtask

    task automatic test_carry_chain();
        logic [W:0] r, exp;
        logic [W-1:0] ones;
        int lat, bc;
        ones = '1;
        exp = '0;
        exp[W] = 1'b1;
        exp = exp - 3;
        do_op(ones, ones, ones, 1'b0, r, lat, bc);
        n_checks++;
        if (r !== exp) begin
            n_fail++;
            $display("FAIL carry_chain got hi %h lo %h want hi %h lo %h",
                     r[W:W-63], r[63:0], exp[W:W-63], exp[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, c1, a2, b2, c2;
        logic [W:0] exp1, exp2, r1, r2;
        int dn, e1, e2;
        logic b19;
        a1 = rand_word(); b1 = rand_word(); c1 = rand_word();
        a2 = rand_word(); b2 = rand_word(); c2 = rand_word();
        exp1 = model(a1, b1, c1, 1'b0);
        exp2 = model(a2, b2, c2, 1'b1);
        dn = 0; e1 = -1; e2 = -1; r1 = '0; r2 = '0; b19 = 1'bx;
        @(negedge clk);
        in_a = a1; in_b = b1; in_c = c1; subtract = 1'b0; start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 6) begin
                // Mid-run change must not affect op 1; it becomes op 2's operands
                in_a = a2; in_b = b2; in_c = c2; subtract = 1'b1;
            end
            if (i == 19) b19 = busy;
            if (done) begin
                dn++;
                if (dn == 1) begin
                    e1 = i;
                    r1 = result;
                end else if (dn == 2) begin
                    e2 = i;
                    r2 = result;
                end
            end
            if (dn >= 2) start = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (dn != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count got %0d want 2", dn);
        end
        n_checks++;
        if (e1 != 18) begin
            n_fail++;
            $display("FAIL b2b_first_done_edge got %0d want 18", e1);
        end
        n_checks++;
        if (e2 != 37) begin
            n_fail++;
            $display("FAIL b2b_second_done_edge got %0d want 37", e2);
        end
        n_checks++;
        if (r1 !== exp1) begin
            n_fail++;
            $display("FAIL b2b_result1 got %h want %h", r1[127:0], exp1[127:0]);
        end
        n_checks++;
        if (r2 !== exp2) begin
            n_fail++;
            $display("FAIL b2b_result2 got %h want %h", r2[127:0], exp2[127:0]);
        end
        n_checks++;
        if (b19 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap_busy got %b want 0", b19);
        end
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dn;
        @(negedge clk);
        in_a = rand_word(); in_b = rand_word(); in_c = rand_word();
        subtract = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL midreset_result got %h want 0", result[127:0]);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_done got %b want 0", done);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy got %b want 0", busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done got %0d want 0", dn);
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] a, b, c;
        logic sub;
        logic [W:0] r, exp;
        int lat, bc;
        for (int k = 0; k < n; k++) begin
            a = rand_word();
            b = rand_word();
            c = rand_word();
            sub = 1'($urandom_range(0, 1));
            exp = model(a, b, c, sub);
            do_op(a, b, c, sub, r, lat, bc);
            n_checks++;
            if (r !== exp) begin
                n_fail++;
                $display("FAIL random_result #%0d sub=%b got hi %h lo %h want hi %h lo %h",
                         k, sub, r[W:W-63], r[63:0], exp[W:W-63], exp[63:0]);
            end
            n_checks++;
            if (lat != 18) begin
                n_fail++;
                $display("FAIL random_latency #%0d got %0d want 18", k, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subtract();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid_run();
        test_random(300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
